frame_scheduler: RTL
====================

# frame_scheduler

Frame job scheduler for the image-filter pipeline. It accepts frame requests (image width/height) from two requesters and arbitrates between them round-robin. For each accepted job it latches the configuration, pulses `start` into the filter top, and counts `pixel_valid` beats until the frame is complete. It then reports completion with a status code and enforces a minimum idle gap before the next frame.

## Interface
Parameters:
- `MIN_SIZE`, 2: smallest legal `size_x` / `size_y`; smaller requests are rejected.
- `GAP`, 4: idle cycles (≥1) inserted after each frame before the next accept.
- `TIMEOUT`, 4096: consecutive RUN cycles without `pixel_valid` that abort a frame.

Ports:
- `clk`  in  1: core clock; all logic on the rising edge.
- `rst`  in  1: system reset, asynchronous, active-low.
- `req_valid`  in  2: per-requester job request; held until accepted.
- `req_ready`  out  2: per-requester accept; a job transfers when `req_valid[i] & req_ready[i]`.
- `req0_size_x`, `req1_size_x`  in  12: requested image width.
- `req0_size_y`, `req1_size_y`  in  12: requested image height.
- `start`  out  1: one-cycle start pulse to the filter top.
- `size_x`, `size_y`  out  12: latched configuration to the filter top, stable for the whole frame.
- `pixel_valid`  in  1: output-pixel strobe from the filter top.
- `busy`  out  1: high in every state except IDLE.
- `done_valid`  out  1: one-cycle completion pulse.
- `done_id`  out  1: requester index of the completed or rejected job.
- `done_status`  out  2: 00 OK, 01 size reject, 10 timeout; 11 is never driven.

## Operation
- States: IDLE, LAUNCH, RUN, GAP, REJECT.
- IDLE:
  - `req_ready` is combinational from `req_valid` and the RR pointer; at most one bit is high, and only in IDLE.
  - Only `req_valid[i]` → grant i. Both → grant the requester not served last; after reset, requester 0 wins.
  - On accept: latch sizes and id, update the RR pointer.
  - Either size < `MIN_SIZE` → REJECT, otherwise → LAUNCH.
- REJECT: `done_valid=1`, status 01 → IDLE. `start` is never pulsed and `size_x`/`size_y` keep their previous values.
- LAUNCH:
  - `start=1` for exactly this cycle.
  - Load `total = size_x*size_y` as an unsigned 24-bit product; the maximum 4095×4095 fits, no overflow.
  - Clear the pixel count and the timeout counter → RUN.
- RUN:
  - Each `pixel_valid` increments the 24-bit count and clears the timeout counter; otherwise the timeout counter increments.
  - `pixel_valid` with count == total−1 → done OK, → GAP.
  - Timeout counter reaching `TIMEOUT` with no strobe in that cycle → done status 10, → GAP. On the same cycle, the final pixel wins over timeout.
- GAP: counts `GAP` cycles → IDLE.
- `pixel_valid` is ignored outside RUN, including during LAUNCH.
- Reset, at any time: returns to IDLE, aborts the frame, no `done_valid`, RR pointer back to requester 0.
- Requester inputs that change while unaccepted have no effect; sizes are sampled only at accept.

## Timing
- Reset values: `req_ready`=0 while `rst` is low, then combinational; `start`=0, `size_x`=`size_y`=0, `busy`=0, `done_valid`=0, `done_id`=0, `done_status`=00.
- Accept at cycle N:
  - `start`=1 and new `size_x`/`size_y` at N+1.
  - RUN from N+2.
- Last `pixel_valid` at cycle M:
  - `done_valid` at M+1, with `done_id`/`done_status` valid that cycle.
  - GAP spans M+1..M+GAP; IDLE with `req_ready` possible at M+GAP+1.
- Reject accepted at N: `done_valid` at N+1; IDLE at N+2.
- `done_id`/`done_status` hold their values after the pulse until the next `done_valid`.
- Back-to-back throughput: one frame per total + GAP + 2 cycles, plus filter latency.

## Structure
- `frame_scheduler_pkg`: state enum, `done_status` codes (`ST_OK`, `ST_SIZE`, `ST_TIMEOUT`), size width 12, count width 24.
- One sub-module, `frame_rr_arbiter`: 2-way round-robin with a last-grant register, `advance` input on accept, reset to requester 0.
- Timeout counter width is `$clog2(TIMEOUT+1)`.

## Test plan
- Single job, req0 4×3, `pixel_valid` every cycle from N+2:
  - `start` at N+1.
  - `done_valid` one cycle after the 12th strobe: id 0, status 00.
  - `req_ready` low for the 4 GAP cycles.
- Both requesters valid continuously (3×2 each): grants alternate 0,1,0,1; each done id matches.
- req1 size_x=1: accept → `done_valid` at N+1 with status 01, no `start`; the next accept is possible at N+2.
- 4×4 job, strobes stop after 5: `done_valid` after `TIMEOUT` idle cycles with status 10; after GAP, a req0 2×2 job completes OK.
- Reset asserted mid-RUN: all outputs return to reset values immediately with no `done_valid`; after release, req1-only arbitration grants req1 and the next contention grants req0.
- 4095×4095 job with constant strobes: done with status 00 after exactly 16769025 strobes; strobes arriving during LAUNCH and GAP are not counted.

Source files
------------

// File: rtl/frame_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : frame_scheduler_pkg                                    |
// | Description : Shared types and constants for the frame scheduler.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package frame_scheduler_pkg;

  localparam int SIZE_W  = 12;  // image width/height field
  localparam int COUNT_W = 24;  // pixel count; holds 4095*4095

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_GAP    = 3'd3,
    S_REJECT = 3'd4
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_SIZE    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/frame_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : frame_rr_arbiter                                       |
// | Description : 2-way round-robin arbiter; priority flips to the       |
// |               requester not granted last whenever advance_i is set.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module frame_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  // prio_q names the requester that wins on contention; 0 after reset
  logic prio_q;
  logic prio_d;

  // Grant the lone requester, or the priority holder when both ask
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = prio_q ? 2'b10 : 2'b01;
    end
    prio_d = prio_q;
    if (advance_i && (grant_o != 2'b00)) begin
      prio_d = ~grant_o[1];
    end
  end

  // Priority register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : frame_scheduler                                        |
// | Description : Accepts frame jobs from two requesters, launches the   |
// |               filter, counts output pixels, reports completion and   |
// |               enforces an idle gap between frames.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int MIN_SIZE = 2,
  parameter int GAP      = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [SIZE_W-1:0] req0_size_x,
  input  logic [SIZE_W-1:0] req0_size_y,
  input  logic [SIZE_W-1:0] req1_size_x,
  input  logic [SIZE_W-1:0] req1_size_y,
  output logic              start,
  output logic [SIZE_W-1:0] size_x,
  output logic [SIZE_W-1:0] size_y,
  input  logic              pixel_valid,
  output logic              busy,
  output logic              done_valid,
  output logic              done_id,
  output logic [1:0]        done_status
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

  state_e             state_q, state_d;
  logic [SIZE_W-1:0]  size_x_q, size_x_d;
  logic [SIZE_W-1:0]  size_y_q, size_y_d;
  logic               id_q, id_d;
  logic [COUNT_W-1:0] total_q, total_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               done_valid_q, done_valid_d;
  logic               done_id_q, done_id_d;
  logic [1:0]         done_status_q, done_status_d;

  logic [1:0]         w_req;
  logic [1:0]         w_grant;
  logic               w_accept;
  logic               w_sel;
  logic [SIZE_W-1:0]  w_sel_x;
  logic [SIZE_W-1:0]  w_sel_y;
  logic               w_reject;
  logic [TMO_W-1:0]   w_tmo_inc;

  // Requests are only visible to the arbiter while idle
  assign w_req    = (state_q == S_IDLE) ? req_valid : 2'b00;
  assign w_accept = |w_grant;
  assign w_sel    = w_grant[1];
  assign w_sel_x  = w_sel ? req1_size_x : req0_size_x;
  assign w_sel_y  = w_sel ? req1_size_y : req0_size_y;
  assign w_reject = (w_sel_x < SIZE_W'(MIN_SIZE)) || (w_sel_y < SIZE_W'(MIN_SIZE));
  assign w_tmo_inc = tmo_q + TMO_W'(1);

  frame_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (w_req),
    .advance_i (w_accept),
    .grant_o   (w_grant)
  );

  // Next-state and datapath updates; start is decoded from LAUNCH
  always_comb begin
    state_d       = state_q;
    size_x_d      = size_x_q;
    size_y_d      = size_y_q;
    id_d          = id_q;
    total_d       = total_q;
    count_d       = count_q;
    tmo_d         = tmo_q;
    gap_d         = gap_q;
    done_valid_d  = 1'b0;
    done_id_d     = done_id_q;
    done_status_d = done_status_q;
    start         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          id_d = w_sel;
          if (w_reject) begin
            // Rejected jobs leave the filter configuration untouched
            state_d       = S_REJECT;
            done_valid_d  = 1'b1;
            done_id_d     = w_sel;
            done_status_d = ST_SIZE;
          end else begin
            size_x_d = w_sel_x;
            size_y_d = w_sel_y;
            state_d  = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        start   = 1'b1;
        total_d = COUNT_W'(size_x_q) * COUNT_W'(size_y_q);
        count_d = '0;
        tmo_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (pixel_valid) begin
          // The last pixel takes precedence over a coincident timeout
          count_d = count_q + COUNT_W'(1);
          tmo_d   = '0;
          if (count_q == total_q - COUNT_W'(1)) begin
            state_d       = S_GAP;
            gap_d         = GAP_W'(GAP - 1);
            done_valid_d  = 1'b1;
            done_id_d     = id_q;
            done_status_d = ST_OK;
          end
        end else begin
          tmo_d = w_tmo_inc;
          if (w_tmo_inc == TMO_W'(TIMEOUT)) begin
            state_d       = S_GAP;
            gap_d         = GAP_W'(GAP - 1);
            done_valid_d  = 1'b1;
            done_id_d     = id_q;
            done_status_d = ST_TIMEOUT;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_REJECT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      size_x_q      <= '0;
      size_y_q      <= '0;
      id_q          <= 1'b0;
      total_q       <= '0;
      count_q       <= '0;
      tmo_q         <= '0;
      gap_q         <= '0;
      done_valid_q  <= 1'b0;
      done_id_q     <= 1'b0;
      done_status_q <= ST_OK;
    end else begin
      state_q       <= state_d;
      size_x_q      <= size_x_d;
      size_y_q      <= size_y_d;
      id_q          <= id_d;
      total_q       <= total_d;
      count_q       <= count_d;
      tmo_q         <= tmo_d;
      gap_q         <= gap_d;
      done_valid_q  <= done_valid_d;
      done_id_q     <= done_id_d;
      done_status_q <= done_status_d;
    end
  end

  // req_ready is forced low while reset is held
  assign req_ready   = w_grant & {2{rst}};
  assign size_x      = size_x_q;
  assign size_y      = size_y_q;
  assign busy        = (state_q != S_IDLE);
  assign done_valid  = done_valid_q;
  assign done_id     = done_id_q;
  assign done_status = done_status_q;

endmodule
`default_nettype wire
